canny_window_engine: RTL

CANNY_WINDOW_ENGINE -- requirements
Module: canny_window_engine

---
 rtl/canny_window_engine.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/canny_window_engine.sv
// canny_window_engine: 5x5 window with Gaussian, Sobel and hysteresis engines, one tap per cycle.
// Define CANNY_DIRECTION_EN to build the Sobel gradient-direction output on OutDir.
module canny_window_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int THRES_HIGH = 15,
  parameter int THRES_LOW  = 10
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic                  bCE,
  input  logic                  bWE,
  input  logic [2:0]            dAddrRegRow,
  input  logic [2:0]            dAddrRegCol,
  input  logic [DATA_WIDTH-1:0] InData,
  input  logic [1:0]            OPMode,
  input  logic                  bOPStart,
  output logic [DATA_WIDTH-1:0] OutData,
  output logic [1:0]            OutDir,
  output logic                  busy,
  output logic                  done
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = DW + 8;
  localparam int SW = DW + 4;
  localparam logic [DW-1:0] TH_HI = DW'(THRES_HIGH);
  localparam logic [DW-1:0] TH_LO = DW'(THRES_LOW);
  localparam logic [4:0] GF [25] = '{
    5'd1, 5'd3,  5'd4,  5'd3,  5'd1,
    5'd3, 5'd7,  5'd10, 5'd7,  5'd3,
    5'd4, 5'd10, 5'd16, 5'd10, 5'd4,
    5'd3, 5'd7,  5'd10, 5'd7,  5'd3,
    5'd1, 5'd3,  5'd4,  5'd3,  5'd1};

  typedef enum logic [1:0] {IDLE, MAC, NORM, DONE} state_t;
  state_t state_q, state_d;

  logic                 start_q;
  logic [1:0]           mode_q;
  logic [2:0]           r_q, c_q;
  logic [AW-1:0]        acc_q;
  logic signed [SW-1:0] gx_q, gy_q;
  logic                 nb_q;
  logic [DW-1:0]        out_q;
  logic [DW-1:0]        win_q [25];

  logic                 gauss, last_tap, hyst;
  logic [2:0]           lim, base;
  logic [4:0]           idx, widx;
  logic [DW-1:0]        pix, res_d;
  logic signed [SW-1:0] sp, gxw, gyw;
  logic [SW-1:0]        ax, ay;
  logic [SW:0]          mag;

  always_comb begin
    gauss    = mode_q == 2'd0;
    lim      = gauss ? 3'd4 : 3'd3;
    base     = gauss ? 3'd0 : 3'd1;
    idx      = 5'(r_q) * 5'd5 + 5'(c_q);
    widx     = 5'(dAddrRegRow) * 5'd5 + 5'(dAddrRegCol);
    pix      = win_q[idx];
    last_tap = r_q == lim && c_q == lim;
    sp       = SW'(pix);
    gxw      = r_q == 3'd2 ? sp <<< 1 : sp;
    gyw      = c_q == 3'd2 ? sp <<< 1 : sp;
    ax       = gx_q[SW-1] ? -gx_q : gx_q;
    ay       = gy_q[SW-1] ? -gy_q : gy_q;
    mag      = {1'b0, ax} + {1'b0, ay};
    hyst     = win_q[12] >= TH_HI || (win_q[12] > TH_LO && nb_q);
    res_d    = gauss ? DW'(acc_q >> 7) : mode_q == 2'd1 ? DW'(mag >> 3) : DW'(hyst);
  end

  always_comb begin
    state_d = state_q;
    state_d = state_q == IDLE ? (start_q ? MAC : IDLE) :
              state_q == MAC  ? (last_tap ? NORM : MAC) :
              state_q == NORM ? DONE : IDLE;
  end

  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;

  // Start is registered once so the first MAC cycle follows the sampling edge by one clock.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      start_q <= 1'b0;
      mode_q  <= 2'd0;
      r_q     <= 3'd0;
      c_q     <= 3'd0;
      acc_q   <= '0;
      gx_q    <= '0;
      gy_q    <= '0;
      nb_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      start_q <= state_q == IDLE && !start_q && !bOPStart && OPMode != 2'd3;
      if (state_q == IDLE && !start_q) mode_q <= OPMode;
      if (state_q == IDLE && start_q) begin
        r_q   <= base;
        c_q   <= base;
        acc_q <= '0;
        gx_q  <= '0;
        gy_q  <= '0;
        nb_q  <= 1'b0;
      end
      if (state_q == MAC) begin
        acc_q <= acc_q + AW'(pix) * AW'(GF[idx]);
        gx_q  <= gx_q + (c_q == 3'd3 ? gxw : c_q == 3'd1 ? -gxw : '0);
        gy_q  <= gy_q + (r_q == 3'd1 ? gyw : r_q == 3'd3 ? -gyw : '0);
        nb_q  <= nb_q | (idx != 5'd12 && pix >= TH_HI);
        c_q   <= c_q == lim ? base : c_q + 3'd1;
        r_q   <= c_q == lim ? r_q + 3'd1 : r_q;
      end
      if (state_q == NORM) out_q <= res_d;
    end
  end

  always_ff @(posedge clk)
    if (!bCE && !bWE && !busy && dAddrRegRow < 3'd5 && dAddrRegCol < 3'd5) win_q[widx] <= InData;

`ifdef CANNY_DIRECTION_EN
  logic [1:0] dir_q, dir_d;
  always_comb begin
    dir_d = 2'd0;
    dir_d = mode_q != 2'd1 ? 2'd0 :
            {ay, 1'b0} <= {1'b0, ax} ? 2'd0 :
            {ax, 1'b0} <= {1'b0, ay} ? 2'd2 :
            gx_q[SW-1] == gy_q[SW-1] ? 2'd1 : 2'd3;
  end
  always_ff @(posedge clk or negedge rst_b)
    if (!rst_b)                dir_q <= 2'd0;
    else if (state_q == NORM)  dir_q <= dir_d;
  assign OutDir = dir_q;
`else
  assign OutDir = 2'd0;
`endif

  assign OutData = out_q;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
endmodule
